// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
package memory_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbFetch = 2'd1,
    ArbData  = 2'd2
  } arb_state_e;

  // funct3 code for a full 32-bit word access
  localparam logic [2:0] WidthWord = 3'b010;

  // addi x0, x0, 0 -- handed to the core when a fetch is aborted
  localparam logic [31:0] NopInstruction = 32'h0000_0013;

  // Bits needed to count from 0 up to and including max_count
  function automatic int unsigned count_width(int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Bundles the core fetch port, core data port and unified memory bus.
interface memory_bus_arbiter_if;

  // Instruction fetch port
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic [31:0] fetch_data;
  logic        fetch_ready;

  // Load/store port
  logic        data_read_enable;
  logic        data_write_enable;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic [2:0]  data_width;
  logic [31:0] data_fetched;
  logic        data_ready;
  logic        bus_error;

  // Shared memory bus
  logic        mem_request;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_width;
  logic [31:0] mem_read_data;
  logic        mem_ack;

  // Arbiter view: serves the core, drives the memory bus
  modport arbiter (
    input  fetch_request, fetch_address,
    output fetch_data, fetch_ready,
    input  data_read_enable, data_write_enable, data_address, data_write_data, data_width,
    output data_fetched, data_ready, bus_error,
    output mem_request, mem_write_enable, mem_address, mem_write_data, mem_width,
    input  mem_read_data, mem_ack
  );

  // Requester (core) view
  modport master (
    output fetch_request, fetch_address,
    input  fetch_data, fetch_ready,
    output data_read_enable, data_write_enable, data_address, data_write_data, data_width,
    input  data_fetched, data_ready, bus_error
  );

  // Memory/interconnect view
  modport slave (
    input  mem_request, mem_write_enable, mem_address, mem_write_data, mem_width,
    output mem_read_data, mem_ack
  );

endinterface

// File: rtl/memory_bus_arbiter_timeout_counter.sv
// Clearable, enabled up-counter; terminal is high during the last allowed cycle.
module memory_bus_arbiter_timeout_counter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CountWidth = count_width(TIMEOUT_CYCLES);
  // Count starts at 0 on the first granted cycle, so cycle N sees N-1
  localparam logic [CountWidth-1:0] LastCount =
      CountWidth'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CountWidth-1:0] count_q, count_d;

  // Next count: clear wins over enable
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CountWidth'(1);
    end
  end

  // Count register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count, only meaningful while a transaction is running
  always_comb begin
    terminal = enable && (count_q == LastCount);
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port memory bus with
// round-robin conflict resolution and an ack timeout.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          DATA_FIRST     = 1'b1
) (
  input logic                   clock,
  input logic                   reset,
  memory_bus_arbiter_if.arbiter bus
);

  arb_state_e state_q, state_d;

  logic        priority_data_q;  // 1: data wins the next conflict
  logic [31:0] address_q;
  logic [31:0] write_data_q;
  logic [2:0]  width_q;
  logic        write_enable_q;
  logic [31:0] fetch_data_q;
  logic [31:0] data_fetched_q;
  logic        fetch_ready_q;
  logic        data_ready_q;
  logic        bus_error_q;

  logic fetch_req;
  logic data_req;
  logic busy;
  logic timeout;
  logic done;
  logic grant_fetch;
  logic grant_data;

  assign fetch_req = bus.fetch_request;
  assign data_req  = bus.data_read_enable | bus.data_write_enable;
  assign busy      = (state_q != ArbIdle);
  // Ack takes precedence over a timeout landing in the same cycle
  assign done      = busy && (bus.mem_ack || timeout);

  memory_bus_arbiter_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (grant_fetch | grant_data),
    .enable  (busy),
    .terminal(timeout)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ArbIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant from IDLE, return to IDLE on ack or timeout
  always_comb begin
    state_d     = state_q;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        if (data_req && (!fetch_req || priority_data_q)) begin
          state_d    = ArbData;
          grant_data = 1'b1;
        end else if (fetch_req) begin
          state_d     = ArbFetch;
          grant_fetch = 1'b1;
        end
      end
      ArbFetch, ArbData: begin
        if (done) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Outputs: bus driven from the grant-time latches so it holds steady
  always_comb begin
    bus.mem_request      = busy;
    bus.mem_write_enable = busy && write_enable_q;
    bus.mem_address      = address_q;
    bus.mem_write_data   = write_data_q;
    bus.mem_width        = width_q;
    bus.fetch_data       = fetch_data_q;
    bus.fetch_ready      = fetch_ready_q;
    bus.data_fetched     = data_fetched_q;
    bus.data_ready       = data_ready_q;
    bus.bus_error        = bus_error_q;
  end

  // Round-robin pointer: flips only when both ports contend
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      priority_data_q <= DATA_FIRST;
    end else if ((state_q == ArbIdle) && fetch_req && data_req) begin
      priority_data_q <= ~priority_data_q;
    end
  end

  // Capture the granted port's request attributes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      address_q      <= '0;
      write_data_q   <= '0;
      width_q        <= '0;
      write_enable_q <= 1'b0;
    end else if (grant_data) begin
      address_q      <= bus.data_address;
      write_data_q   <= bus.data_write_data;
      width_q        <= bus.data_width;
      write_enable_q <= bus.data_write_enable;  // store wins if both enables set
    end else if (grant_fetch) begin
      address_q      <= bus.fetch_address;
      write_data_q   <= '0;
      width_q        <= WidthWord;
      write_enable_q <= 1'b0;
    end
  end

  // Completion: result registers and one-cycle ready/error pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_data_q   <= '0;
      data_fetched_q <= '0;
      fetch_ready_q  <= 1'b0;
      data_ready_q   <= 1'b0;
      bus_error_q    <= 1'b0;
    end else begin
      fetch_ready_q <= done && (state_q == ArbFetch);
      data_ready_q  <= done && (state_q == ArbData);
      bus_error_q   <= done && !bus.mem_ack;
      if (done && (state_q == ArbFetch)) begin
        fetch_data_q <= bus.mem_ack ? bus.mem_read_data : NopInstruction;
      end
      if (done && (state_q == ArbData)) begin
        if (!bus.mem_ack) begin
          data_fetched_q <= '0;
        end else if (!write_enable_q) begin
          data_fetched_q <= bus.mem_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter (TIMEOUT_CYCLES=8, DATA_FIRST=1).
module tb_memory_bus_arbiter;

  logic clock;
  logic reset;
  int   total_checks;
  int   passed_checks;
  int   failed_checks;

  memory_bus_arbiter_if bus ();

  memory_bus_arbiter #(
    .TIMEOUT_CYCLES(8),
    .DATA_FIRST    (1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fetch_request     = 1'b0;
    bus.fetch_address     = '0;
    bus.data_read_enable  = 1'b0;
    bus.data_write_enable = 1'b0;
    bus.data_address      = '0;
    bus.data_write_data   = '0;
    bus.data_width        = '0;
    bus.mem_read_data     = '0;
    bus.mem_ack           = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] ored;
    ored = 32'(bus.mem_request) | 32'(bus.mem_write_enable) | bus.mem_address |
           bus.mem_write_data | 32'(bus.mem_width) | bus.fetch_data | 32'(bus.fetch_ready) |
           bus.data_fetched | 32'(bus.data_ready) | 32'(bus.bus_error);
    check(tag, ored, 32'h0);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    failed_checks = 0;
    reset = 1'b0;
    clear_inputs();

    // Reset state
    #3;
    check_all_zero("reset_outputs");
    tick();
    tick();
    #2 reset = 1'b1;
    tick();
    check("idle_no_request", 32'(bus.mem_request), 32'h0);

    // Fetch only, ack in first granted cycle
    bus.fetch_request = 1'b1;
    bus.fetch_address = 32'h0000_0040;
    tick();
    check("fetch_mem_request", 32'(bus.mem_request), 32'h1);
    check("fetch_mem_address", bus.mem_address, 32'h0000_0040);
    check("fetch_mem_width", 32'(bus.mem_width), 32'h2);
    check("fetch_mem_we", 32'(bus.mem_write_enable), 32'h0);
    check("fetch_ready_early", 32'(bus.fetch_ready), 32'h0);
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'h0050_0093;
    tick();
    check("fetch_ready_pulse", 32'(bus.fetch_ready), 32'h1);
    check("fetch_data", bus.fetch_data, 32'h0050_0093);
    check("fetch_req_dropped", 32'(bus.mem_request), 32'h0);
    clear_inputs();
    tick();
    check("fetch_ready_single", 32'(bus.fetch_ready), 32'h0);

    // Store with 4 wait cycles
    bus.data_write_enable = 1'b1;
    bus.data_address      = 32'h0000_1000;
    bus.data_write_data   = 32'hDEAD_BEEF;
    bus.data_width        = 3'b000;
    bus.mem_read_data     = 32'h1234_5678;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("store_mem_request", 32'(bus.mem_request), 32'h1);
      check("store_mem_we", 32'(bus.mem_write_enable), 32'h1);
      check("store_mem_address", bus.mem_address, 32'h0000_1000);
      check("store_mem_wdata", bus.mem_write_data, 32'hDEAD_BEEF);
      check("store_mem_width", 32'(bus.mem_width), 32'h0);
      check("store_ready_early", 32'(bus.data_ready), 32'h0);
      if (k == 5) bus.mem_ack = 1'b1;
    end
    tick();
    check("store_ready_pulse", 32'(bus.data_ready), 32'h1);
    check("store_data_fetched", bus.data_fetched, 32'h0);
    check("store_no_error", 32'(bus.bus_error), 32'h0);
    check("store_req_dropped", 32'(bus.mem_request), 32'h0);
    clear_inputs();
    tick();
    check("store_ready_single", 32'(bus.data_ready), 32'h0);

    // Conflict: round-robin starting with data, ack held high throughout
    bus.fetch_request    = 1'b1;
    bus.fetch_address    = 32'h0000_0100;
    bus.data_read_enable = 1'b1;
    bus.data_address     = 32'h0000_2000;
    bus.mem_ack          = 1'b1;
    bus.mem_read_data    = 32'hAAAA_0001;
    tick();
    check("rr_grant1_data", bus.mem_address, 32'h0000_2000);
    tick();
    check("rr_data_ready1", 32'(bus.data_ready), 32'h1);
    tick();
    check("rr_grant2_fetch", bus.mem_address, 32'h0000_0100);
    tick();
    check("rr_fetch_ready2", 32'(bus.fetch_ready), 32'h1);
    tick();
    check("rr_grant3_data", bus.mem_address, 32'h0000_2000);
    tick();
    tick();
    check("rr_grant4_fetch", bus.mem_address, 32'h0000_0100);
    check("rr_grant4_we", 32'(bus.mem_write_enable), 32'h0);
    tick();
    check("rr_fetch_data", bus.fetch_data, 32'hAAAA_0001);
    check("rr_data_fetched", bus.data_fetched, 32'hAAAA_0001);
    clear_inputs();
    tick();

    // Input instability after grant
    bus.data_read_enable = 1'b1;
    bus.data_address     = 32'h0000_3000;
    bus.data_width       = 3'b100;
    tick();
    check("unstable_addr_grant", bus.mem_address, 32'h0000_3000);
    bus.data_address = 32'h0000_4000;
    bus.data_width   = 3'b001;
    tick();
    check("unstable_addr_held", bus.mem_address, 32'h0000_3000);
    check("unstable_width_held", 32'(bus.mem_width), 32'h4);
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'hCAFE_F00D;
    tick();
    check("unstable_ready", 32'(bus.data_ready), 32'h1);
    check("unstable_load_data", bus.data_fetched, 32'hCAFE_F00D);
    clear_inputs();
    tick();

    // Timeout on a fetch: 8 granted cycles, then error + NOP
    bus.fetch_request = 1'b1;
    bus.fetch_address = 32'h0000_0080;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("timeout_req_held", 32'(bus.mem_request), 32'h1);
      check("timeout_no_error_yet", 32'(bus.bus_error), 32'h0);
    end
    tick();
    check("timeout_req_dropped", 32'(bus.mem_request), 32'h0);
    check("timeout_bus_error", 32'(bus.bus_error), 32'h1);
    check("timeout_fetch_ready", 32'(bus.fetch_ready), 32'h1);
    check("timeout_nop", bus.fetch_data, 32'h0000_0013);
    clear_inputs();
    tick();
    check("timeout_error_single", 32'(bus.bus_error), 32'h0);

    // Reset in the middle of a data transaction
    bus.data_write_enable = 1'b1;
    bus.data_address      = 32'h0000_5000;
    bus.data_write_data   = 32'h0000_0011;
    tick();
    check("midreset_granted", 32'(bus.mem_request), 32'h1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("midreset_outputs");
    clear_inputs();
    tick();
    #2 reset = 1'b1;
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'h7777_7777;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_reset_idle", 32'(bus.mem_request), 32'h0);
      check("post_reset_no_ready",
            32'(bus.data_ready) | 32'(bus.fetch_ready) | 32'(bus.bus_error), 32'h0);
    end
    check("post_reset_data_fetched", bus.data_fetched, 32'h0);
    clear_inputs();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
